cache_2way_ctrl: RTL
====================

Name: cache_2way_ctrl

Overview:
Controller for the 2-way set-associative cache built from the data_block0/1 and tag0/1 RAMs.
It accepts one CPU word request at a time and performs the tag lookup and hit/miss decision. It maintains LRU state through the used bit, writes back a dirty victim, and refills a missing block from main memory over a req/ack handshake.
It also clears every tag entry after reset, so the cache starts empty.

Parameters:
INDEX_BIT, 10, set index width.
TAG_BIT, 23, tag entry width: {tag[TAG_BIT-1:3], dirty[2], used[1], valid[0]}.
BLOCK_SIZE_WORDS, 4, words per block. Fixed at 4; the word offset is 2 bits.
NUMBER_OF_SETS, 1000, number of implemented sets. Any index ≥ NUMBER_OF_SETS is illegal.
ADDR_BIT, 32, CPU word-address width. ADDR_BIT = (TAG_BIT-3) + INDEX_BIT + 2.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  synchronous, active-low reset.
cpu_req, cpu_we  in  1,1  request strobe; 1 = write.
cpu_addr  in  ADDR_BIT  word address: [1:0] word offset, [INDEX_BIT+1:2] index, upper bits tag.
cpu_wdata  in  32  write data.
cpu_ready  out  1  high only in IDLE; a request is accepted when cpu_req && cpu_ready.
cpu_done, cpu_err  out  1,1  one-cycle completion pulse; cpu_err is valid with cpu_done.
cpu_rdata  out  32  read word; valid when cpu_done is high and held until the next accept.
ram_addr  out  INDEX_BIT  set address shared by all four RAMs. RAM read data is valid the cycle after ram_addr is presented.
tag0_we, tag1_we, data0_we, data1_we  out  1 each  RAM write enables.
tag0_wdata, tag1_wdata  out  TAG_BIT  tag write data.
data_wdata  out  32*BLOCK_SIZE_WORDS  block write data, shared by both data RAMs.
tag0_rdata, tag1_rdata  in  TAG_BIT  tag read data.
data0_rdata, data1_rdata  in  32*BLOCK_SIZE_WORDS  block read data.
mem_req, mem_we  out  1,1  main-memory request; mem_we = 1 means write-back.
mem_addr  out  ADDR_BIT  block word address {tag, index, 2'b00}.
mem_wdata  out  32*BLOCK_SIZE_WORDS  write-back block.
mem_ack  in  1  one-cycle completion from memory.
mem_rdata  in  32*BLOCK_SIZE_WORDS  refill block; valid with mem_ack.

Behaviour:
- Reset values: all outputs 0; state INIT; init counter 0.
- INIT: each cycle write 0 to both tag RAMs at ram_addr = counter, then increment the counter. After NUMBER_OF_SETS-1 go to IDLE. This takes NUMBER_OF_SETS cycles and cpu_ready stays 0 throughout. Data RAMs are untouched.
- Word ordering within a block: offset 0 → [127:96], 1 → [95:64], 2 → [63:32], 3 → [31:0].
- IDLE, on accept:
  - Latch we, addr and wdata.
  - If index ≥ NUMBER_OF_SETS, go to ERR. ERR pulses cpu_done=cpu_err=1 on the next cycle with no RAM or memory activity, then returns to IDLE.
  - Otherwise drive ram_addr and go to LOOKUP.
- LOOKUP: one cycle for the RAM reads, then go to COMPARE.
- COMPARE: hit_w = valid_w && tag_w == latched tag.
  - Hit in way w:
    - Set used_w=1 and clear used in the other way (both tags rewritten).
    - On a write, merge cpu_wdata into the block, write data_w, and set dirty_w.
    - Go to RESP.
  - Miss: choose the victim: the first invalid way (way0 before way1), else the way with used=0, else way0. Go to WB if the victim is valid and dirty, otherwise to REFILL.
- WB:
  - Drive mem_req=1, mem_we=1, mem_addr={victim tag, index, 2'b00}, mem_wdata = victim block, and hold them until mem_ack.
  - On mem_ack, go to REFILL with mem_req=0 the following cycle.
- REFILL:
  - Drive mem_req=1, mem_we=0, mem_addr = requested block, and hold until mem_ack.
  - On mem_ack, capture mem_rdata and go to UPDATE.
- UPDATE:
  - Write the victim data RAM with the refilled block; on a write, cpu_wdata is merged in first.
  - Write the victim tag as {tag, dirty=we, used=1, valid=1}. Clear the other way's used bit, preserving its tag, dirty and valid bits.
  - Go to RESP.
- RESP: pulse cpu_done; cpu_rdata = the selected word (the write data on a write); go to IDLE.
- Latencies:
  - Hit: cpu_done 3 cycles after the accept edge.
  - Clean miss: 2 cycles after the refill mem_ack.
- Memory handshake: mem_ack arriving while mem_req=0 is ignored. The controller never drops mem_req before mem_ack.
- cpu_req while cpu_ready=0 is ignored; no queuing.
- Reset mid-operation: the next edge forces all outputs to 0 and the state to INIT. Any outstanding mem transaction is abandoned and memory must tolerate this. Full re-initialisation follows.
- cpu_addr is latched at accept, so it may change afterwards without effect.

Test Plan:
1. Hold rst_n low 2 cycles, then release → cpu_ready=0 for exactly 1000 cycles; tag0_we=tag1_we=1 with wdata 0 for ram_addr 0..999; then cpu_ready=1.
2. Read 0x0000_1004, memory returns {A,B,C,D} → mem_req read at 0x0000_1004; cpu_rdata=A; tag0 written {20'h1,0,1,1}.
3. Read 0x0000_1006 again → no mem_req; cpu_done 3 cycles after accept; cpu_rdata=C.
4. Write 0x0000_1005=0xDEADBEEF, then read 0x0000_2004 (fills way1), then read 0x0000_3004:
   - The write hits way0 and sets its dirty bit.
   - The final read writes back way0 (mem_we=1, mem_addr 0x0000_1004, mem_wdata[95:64]=0xDEADBEEF), then refills way0 with tag 3.
5. Read 0x0000_0FA0 (index 1000) → cpu_done=cpu_err=1 on the next cycle; no RAM write enables; mem_req=0.
6. Assert rst_n=0 during REFILL while mem_req=1 and before mem_ack → mem_req=0 on the next edge; the INIT sweep restarts; a late mem_ack is ignored.

Source files
------------

// File: rtl/cache_2way_ctrl.sv
// Two-way set-associative cache controller: tag lookup, LRU via the used bit,
// dirty-victim write-back and block refill over a req/ack memory handshake.
module cache_2way_ctrl #(
  parameter int INDEX_BIT        = 10,
  parameter int TAG_BIT          = 23,
  parameter int BLOCK_SIZE_WORDS = 4,
  parameter int NUMBER_OF_SETS   = 1000,
  parameter int ADDR_BIT         = (TAG_BIT-3) + INDEX_BIT + 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [ADDR_BIT-1:0]           cpu_addr,
  input  logic [31:0]                   cpu_wdata,
  output logic                          cpu_ready,
  output logic                          cpu_done,
  output logic                          cpu_err,
  output logic [31:0]                   cpu_rdata,
  output logic [INDEX_BIT-1:0]          ram_addr,
  output logic                          tag0_we,
  output logic                          tag1_we,
  output logic                          data0_we,
  output logic                          data1_we,
  output logic [TAG_BIT-1:0]            tag0_wdata,
  output logic [TAG_BIT-1:0]            tag1_wdata,
  output logic [32*BLOCK_SIZE_WORDS-1:0] data_wdata,
  input  logic [TAG_BIT-1:0]            tag0_rdata,
  input  logic [TAG_BIT-1:0]            tag1_rdata,
  input  logic [32*BLOCK_SIZE_WORDS-1:0] data0_rdata,
  input  logic [32*BLOCK_SIZE_WORDS-1:0] data1_rdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_BIT-1:0]           mem_addr,
  output logic [32*BLOCK_SIZE_WORDS-1:0] mem_wdata,
  input  logic                          mem_ack,
  input  logic [32*BLOCK_SIZE_WORDS-1:0] mem_rdata
);
  localparam int BW = 32*BLOCK_SIZE_WORDS;
  localparam int TW = TAG_BIT-3;
  localparam logic [INDEX_BIT-1:0] LAST_SET = INDEX_BIT'(NUMBER_OF_SETS-1);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_COMPARE, S_WB, S_REFILL, S_UPDATE, S_RESP, S_ERR
  } state_t;

  state_t                state_q;
  logic [INDEX_BIT-1:0]  cnt_q, ram_addr_q;
  logic                  we_q, vic1_q;
  logic [ADDR_BIT-1:0]   addr_q, mem_addr_q;
  logic [31:0]           wdata_q, cpu_rdata_q;
  logic [TAG_BIT-1:0]    otag0_q, otag1_q, tag0_wdata_q, tag1_wdata_q;
  logic [BW-1:0]         blk_q, data_wdata_q, mem_wdata_q;
  logic                  ready_q, done_q, err_q, mem_req_q, mem_we_q;
  logic                  tag0_we_q, tag1_we_q, data0_we_q, data1_we_q;

  function automatic logic [BW-1:0] merge(input logic [BW-1:0] b, input logic [1:0] o,
                                          input logic [31:0] w);
    logic [BW-1:0] r;
    r = b;
    r[(BLOCK_SIZE_WORDS-1-int'(o))*32 +: 32] = w;
    return r;
  endfunction

  logic [TW-1:0]        req_tag;
  logic [INDEX_BIT-1:0] idx;
  logic [1:0]           off;
  logic                 hit0, hit1, vic1;
  logic [TAG_BIT-1:0]   vtag;
  logic [BW-1:0]        vblk, hblk;

  always_comb begin
    req_tag = addr_q[ADDR_BIT-1:INDEX_BIT+2];
    idx     = addr_q[INDEX_BIT+1:2];
    off     = addr_q[1:0];
    hit0    = tag0_rdata[0] && (tag0_rdata[TAG_BIT-1:3] == req_tag);
    hit1    = tag1_rdata[0] && (tag1_rdata[TAG_BIT-1:3] == req_tag) && !hit0;
    // Victim: first invalid way, else the not-recently-used way, else way0.
    vic1    = tag0_rdata[0] && (!tag1_rdata[0] || (tag0_rdata[1] && !tag1_rdata[1]));
    vtag    = vic1 ? tag1_rdata : tag0_rdata;
    vblk    = vic1 ? data1_rdata : data0_rdata;
    hblk    = hit0 ? data0_rdata : data1_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;       cnt_q <= '0;         ram_addr_q <= '0;
      we_q <= 1'b0;            vic1_q <= 1'b0;      addr_q <= '0;
      mem_addr_q <= '0;        wdata_q <= '0;       cpu_rdata_q <= '0;
      otag0_q <= '0;           otag1_q <= '0;       tag0_wdata_q <= '0;
      tag1_wdata_q <= '0;      blk_q <= '0;         data_wdata_q <= '0;
      mem_wdata_q <= '0;       ready_q <= 1'b0;     done_q <= 1'b0;
      err_q <= 1'b0;           mem_req_q <= 1'b0;   mem_we_q <= 1'b0;
      tag0_we_q <= 1'b0;       tag1_we_q <= 1'b0;
      data0_we_q <= 1'b0;      data1_we_q <= 1'b0;
    end else begin
      tag0_we_q  <= 1'b0;
      tag1_we_q  <= 1'b0;
      data0_we_q <= 1'b0;
      data1_we_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        S_INIT: begin
          ram_addr_q   <= cnt_q;
          tag0_we_q    <= 1'b1;
          tag1_we_q    <= 1'b1;
          tag0_wdata_q <= '0;
          tag1_wdata_q <= '0;
          cnt_q        <= cnt_q + 1'b1;
          if (cnt_q == LAST_SET) begin
            cnt_q   <= '0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_IDLE: if (cpu_req) begin
          ready_q <= 1'b0;
          we_q    <= cpu_we;
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
          if (int'(cpu_addr[INDEX_BIT+1:2]) >= NUMBER_OF_SETS) begin
            state_q <= S_ERR;
          end else begin
            ram_addr_q <= cpu_addr[INDEX_BIT+1:2];
            state_q    <= S_LOOKUP;
          end
        end
        S_LOOKUP: state_q <= S_COMPARE;
        S_COMPARE: begin
          otag0_q <= tag0_rdata;
          otag1_q <= tag1_rdata;
          vic1_q  <= vic1;
          if (hit0 || hit1) begin
            tag0_we_q    <= 1'b1;
            tag1_we_q    <= 1'b1;
            tag0_wdata_q <= {tag0_rdata[TAG_BIT-1:3], tag0_rdata[2] | (we_q & hit0),
                             hit0, tag0_rdata[0]};
            tag1_wdata_q <= {tag1_rdata[TAG_BIT-1:3], tag1_rdata[2] | (we_q & hit1),
                             hit1, tag1_rdata[0]};
            data_wdata_q <= merge(hblk, off, wdata_q);
            data0_we_q   <= we_q & hit0;
            data1_we_q   <= we_q & hit1;
            blk_q        <= hblk;
            state_q      <= S_RESP;
          end else if (vtag[0] && vtag[2]) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {vtag[TAG_BIT-1:3], idx, 2'b00};
            mem_wdata_q <= vblk;
            state_q     <= S_WB;
          end else begin
            state_q <= S_REFILL;
          end
        end
        S_WB: if (mem_ack) begin
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          state_q   <= S_REFILL;
        end
        // Enters with mem_req low, raises it, then waits for the ack.
        S_REFILL: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {req_tag, idx, 2'b00};
          end else if (mem_ack) begin
            mem_req_q <= 1'b0;
            blk_q     <= mem_rdata;
            state_q   <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          data_wdata_q <= we_q ? merge(blk_q, off, wdata_q) : blk_q;
          data0_we_q   <= !vic1_q;
          data1_we_q   <= vic1_q;
          tag0_we_q    <= 1'b1;
          tag1_we_q    <= 1'b1;
          tag0_wdata_q <= vic1_q ? {otag0_q[TAG_BIT-1:2], 1'b0, otag0_q[0]}
                                 : {req_tag, we_q, 1'b1, 1'b1};
          tag1_wdata_q <= vic1_q ? {req_tag, we_q, 1'b1, 1'b1}
                                 : {otag1_q[TAG_BIT-1:2], 1'b0, otag1_q[0]};
          state_q      <= S_RESP;
        end
        S_RESP: begin
          done_q      <= 1'b1;
          cpu_rdata_q <= we_q ? wdata_q : blk_q[(BLOCK_SIZE_WORDS-1-int'(off))*32 +: 32];
          ready_q     <= 1'b1;
          state_q     <= S_IDLE;
        end
        S_ERR: begin
          done_q  <= 1'b1;
          err_q   <= 1'b1;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign cpu_ready  = ready_q;
  assign cpu_done   = done_q;
  assign cpu_err    = err_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ram_addr   = ram_addr_q;
  assign tag0_we    = tag0_we_q;
  assign tag1_we    = tag1_we_q;
  assign data0_we   = data0_we_q;
  assign data1_we   = data1_we_q;
  assign tag0_wdata = tag0_wdata_q;
  assign tag1_wdata = tag1_wdata_q;
  assign data_wdata = data_wdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
endmodule
